daq_register_bank: RTL and testbench

Parametrised host register bank for the DAQ datapath: a block of read/write control registers, a read-only region holding the latest multi-byte conversion result of every ADC channel, and a sticky overrun status register. Multi-byte conversion reads are made coherent by a snapshot taken on the most-significant-byte read. The bank sits between the host interface and the conversion pipeline and generalises the single-word register file to N channels, registered reads and status flags.

---
 rtl/daq_regbank_pkg.sv | 50 +++++
 rtl/conv_channel_slot.sv | 57 +++++
 rtl/daq_register_bank.sv | 110 +++++++++++
 tb/tb_daq_register_bank.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/daq_regbank_pkg.sv
// Shared types and address decode for the DAQ host register bank.
package daq_regbank_pkg;

  localparam int DEF_WIDTH      = 8;
  localparam int DEF_DEPTH      = 16;
  localparam int DEF_N_CH       = 4;
  localparam int DEF_CONV_BYTES = 3;

  typedef enum logic [1:0] {
    REG_CTRL,
    REG_CONV,
    REG_STATUS,
    REG_NONE
  } region_e;

  typedef struct packed {
    region_e    region;
    logic [7:0] ch;
    logic [7:0] bsel;
  } dec_t;

  // Control block first, then CONV_BYTES registers per channel (MSB first), then STATUS.
  function automatic dec_t decode(input int addr, input int depth, input int n_ch,
                                  input int conv_bytes);
    dec_t d;
    int   off;
    d.region = REG_NONE;
    d.ch     = '0;
    d.bsel   = '0;
    off      = addr - depth;
    if (addr < depth) begin
      d.region = REG_CTRL;
    end else if (off < n_ch * conv_bytes) begin
      d.region = REG_CONV;
      d.ch     = 8'(off / conv_bytes);
      d.bsel   = 8'(off % conv_bytes);
    end else if (off == n_ch * conv_bytes) begin
      d.region = REG_STATUS;
    end
    return d;
  endfunction

  function automatic region_e region_of(input int addr, input int depth, input int n_ch,
                                        input int conv_bytes);
    dec_t d;
    d = decode(addr, depth, n_ch, conv_bytes);
    return d.region;
  endfunction

endpackage

// File: rtl/conv_channel_slot.sv
// Per-channel conversion storage: live word, read snapshot, unread and sticky overrun flags.
module conv_channel_slot #(
  parameter  int WIDTH      = 8,
  parameter  int CONV_BYTES = 3,
  localparam int CONV_W     = WIDTH * CONV_BYTES,
  localparam int SH_W       = CONV_W - WIDTH
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              clear_i,
  input  logic              conv_hit_i,
  input  logic              snap_i,
  input  logic              status_rd_i,
  input  logic [CONV_W-1:0] conv_data_i,
  input  logic [7:0]        byte_sel_i,
  output logic [CONV_W-1:0] live_o,
  output logic [WIDTH-1:0]  rd_byte_o,
  output logic              overrun_o
);

  logic [CONV_W-1:0] live;
  // The MSB is always served from live, so only the lower bytes need a shadow copy.
  logic [SH_W-1:0]   shadow;
  logic              unread;
  logic              overrun;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      live    <= '0;
      shadow  <= '0;
      unread  <= 1'b0;
      overrun <= 1'b0;
    end else if (clear_i) begin
      live    <= '0;
      shadow  <= '0;
      unread  <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (conv_hit_i) live <= conv_data_i;
      if (snap_i) shadow <= live[SH_W-1:0];
      if (conv_hit_i) unread <= 1'b1;
      else if (snap_i) unread <= 1'b0;
      overrun <= (overrun && !status_rd_i) || (conv_hit_i && unread && !snap_i);
    end
  end

  always_comb begin
    rd_byte_o = live[CONV_W-1 -: WIDTH];
    for (int k = 1; k < CONV_BYTES; k++) begin
      if (byte_sel_i == 8'(k)) rd_byte_o = shadow[(CONV_BYTES-1-k)*WIDTH +: WIDTH];
    end
  end

  assign live_o    = live;
  assign overrun_o = overrun;

endmodule

// File: rtl/daq_register_bank.sv
// Host register bank: RW control block, per-channel conversion readback with MSB snapshot, sticky overrun STATUS.
module daq_register_bank
  import daq_regbank_pkg::*;
#(
  parameter  int WIDTH      = DEF_WIDTH,
  parameter  int DEPTH      = DEF_DEPTH,
  parameter  int N_CH       = DEF_N_CH,
  parameter  int CONV_BYTES = DEF_CONV_BYTES,
  localparam int CONV_W     = CONV_BYTES * WIDTH,
  localparam int ADDR_W     = $clog2(DEPTH + N_CH * CONV_BYTES + 1),
  localparam int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic                   clear_i,
  input  logic [ADDR_W-1:0]      sel_in_i,
  input  logic                   load_i,
  input  logic [WIDTH-1:0]       in_i,
  input  logic [ADDR_W-1:0]      sel_out_i,
  input  logic                   read_i,
  output logic [WIDTH-1:0]       out_o,
  output logic                   out_valid_o,
  output logic                   write_err_o,
  input  logic                   conv_valid_i,
  input  logic [CH_W-1:0]        conv_ch_i,
  input  logic [CONV_W-1:0]      conv_data_i,
  output logic [N_CH*CONV_W-1:0] out_conversion_o,
  output logic [N_CH-1:0]        overrun_o
);

  localparam int CI_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] ctrl    [DEPTH];
  logic [WIDTH-1:0] ch_byte [N_CH];
  logic [WIDTH-1:0] conv_byte;
  dec_t             rd_dec;
  region_e          wr_region;
  logic             status_rd;

  assign rd_dec    = decode(int'(sel_out_i), DEPTH, N_CH, CONV_BYTES);
  assign wr_region = region_of(int'(sel_in_i), DEPTH, N_CH, CONV_BYTES);
  assign status_rd = read_i && (rd_dec.region == REG_STATUS);

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic conv_hit;
    logic snap;

    assign conv_hit = conv_valid_i && (conv_ch_i == CH_W'(c));
    assign snap     = read_i && (rd_dec.region == REG_CONV) &&
                      (rd_dec.ch == 8'(c)) && (rd_dec.bsel == 8'd0);

    conv_channel_slot #(
      .WIDTH      (WIDTH),
      .CONV_BYTES (CONV_BYTES)
    ) u_slot (
      .clock_i     (clock_i),
      .reset_i     (reset_i),
      .clear_i     (clear_i),
      .conv_hit_i  (conv_hit),
      .snap_i      (snap),
      .status_rd_i (status_rd),
      .conv_data_i (conv_data_i),
      .byte_sel_i  (rd_dec.bsel),
      .live_o      (out_conversion_o[c*CONV_W +: CONV_W]),
      .rd_byte_o   (ch_byte[c]),
      .overrun_o   (overrun_o[c])
    );
  end

  always_comb begin
    conv_byte = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (rd_dec.ch == 8'(c)) conv_byte = ch_byte[c];
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < DEPTH; i++) ctrl[i] <= '0;
    end else if (clear_i) begin
      for (int i = 0; i < DEPTH; i++) ctrl[i] <= '0;
    end else if (load_i && (wr_region == REG_CTRL)) begin
      ctrl[sel_in_i[CI_W-1:0]] <= in_i;
    end
  end

  // Read data is sampled from pre-edge state, so same-cycle writes are not bypassed.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      out_o       <= '0;
      out_valid_o <= 1'b0;
      write_err_o <= 1'b0;
    end else if (clear_i) begin
      out_valid_o <= 1'b0;
      write_err_o <= 1'b0;
    end else begin
      out_valid_o <= read_i;
      write_err_o <= load_i && (wr_region != REG_CTRL);
      if (read_i) begin
        case (rd_dec.region)
          REG_CTRL:   out_o <= ctrl[sel_out_i[CI_W-1:0]];
          REG_CONV:   out_o <= conv_byte;
          REG_STATUS: out_o <= WIDTH'(overrun_o);
          default:    out_o <= '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_daq_register_bank.sv
// Directed and randomized checks of daq_register_bank against a behavioural address-map model.
module tb_daq_register_bank;

  localparam int ST = 28;

  logic        clock_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        clear_i = 1'b0;
  logic [4:0]  sel_in_i = '0;
  logic        load_i = 1'b0;
  logic [7:0]  in_i = '0;
  logic [4:0]  sel_out_i = '0;
  logic        read_i = 1'b0;
  logic [7:0]  out_o;
  logic        out_valid_o;
  logic        write_err_o;
  logic        conv_valid_i = 1'b0;
  logic [1:0]  conv_ch_i = '0;
  logic [23:0] conv_data_i = '0;
  logic [95:0] out_conversion_o;
  logic [3:0]  overrun_o;

  daq_register_bank dut (
    .clock_i(clock_i), .reset_i(reset_i), .clear_i(clear_i),
    .sel_in_i(sel_in_i), .load_i(load_i), .in_i(in_i),
    .sel_out_i(sel_out_i), .read_i(read_i), .out_o(out_o),
    .out_valid_o(out_valid_o), .write_err_o(write_err_o),
    .conv_valid_i(conv_valid_i), .conv_ch_i(conv_ch_i), .conv_data_i(conv_data_i),
    .out_conversion_o(out_conversion_o), .overrun_o(overrun_o)
  );

  always #5 clock_i = ~clock_i;

  int checks = 0;
  int errors = 0;

  logic [7:0]  m_ctrl   [16];
  logic [23:0] m_live   [4];
  logic [23:0] m_shadow [4];
  bit          m_unread [4];
  logic [3:0]  m_ovr;
  logic [7:0]  m_out;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_ctrl[i] = '0;
    for (int c = 0; c < 4; c++) begin
      m_live[c] = '0; m_shadow[c] = '0; m_unread[c] = 0;
    end
    m_ovr = '0;
    m_out = '0;
  endtask

  // One clock cycle: drive at negedge, update the model, check everything at the next negedge.
  task automatic step(input bit clr, input bit ld, input int wa, input logic [7:0] wd,
                      input bit rd, input int ra, input bit cv, input int cch,
                      input logic [23:0] cd);
    bit ev, ee, srd;
    int c, k, snap;
    clear_i = clr; load_i = ld; sel_in_i = 5'(wa); in_i = wd;
    read_i = rd; sel_out_i = 5'(ra);
    conv_valid_i = cv; conv_ch_i = 2'(cch); conv_data_i = cd;
    ev = 0; ee = 0; srd = 0; snap = -1;
    if (clr) begin
      for (int i = 0; i < 16; i++) m_ctrl[i] = '0;
      for (int j = 0; j < 4; j++) begin
        m_live[j] = '0; m_shadow[j] = '0; m_unread[j] = 0;
      end
      m_ovr = '0;
    end else begin
      ee = ld && (wa >= 16);
      ev = rd;
      if (rd) begin
        if (ra < 16) m_out = m_ctrl[ra];
        else if (ra < ST) begin
          c = (ra - 16) / 3;
          k = (ra - 16) % 3;
          if (k == 0) begin
            m_out = m_live[c][23:16];
            snap  = c;
          end else m_out = 8'(m_shadow[c] >> (8 * (2 - k)));
        end else if (ra == ST) begin
          m_out = {4'b0, m_ovr};
          srd   = 1;
        end else m_out = '0;
      end
      if (srd) m_ovr = '0;
      if (cv && m_unread[cch] && snap != cch) m_ovr[cch] = 1'b1;
      if (snap >= 0) begin
        m_shadow[snap] = m_live[snap];
        m_unread[snap] = 0;
      end
      if (cv) begin
        m_live[cch]   = cd;
        m_unread[cch] = 1;
      end
      if (ld && wa < 16) m_ctrl[wa] = wd;
    end
    @(negedge clock_i);
    chk("out_valid", 96'(out_valid_o), 96'(ev));
    chk("write_err", 96'(write_err_o), 96'(ee));
    chk("out", 96'(out_o), 96'(m_out));
    chk("conversion", out_conversion_o, {m_live[3], m_live[2], m_live[1], m_live[0]});
    chk("overrun", 96'(overrun_o), 96'(m_ovr));
  endtask

  task automatic wr(input int a, input logic [7:0] d);
    step(0, 1, a, d, 0, 0, 0, 0, 24'h0);
  endtask
  task automatic rdx(input int a);
    step(0, 0, 0, 8'h0, 1, a, 0, 0, 24'h0);
  endtask
  task automatic cvx(input int ch, input logic [23:0] d);
    step(0, 0, 0, 8'h0, 0, 0, 1, ch, d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #1;
    chk("reset_out", 96'(out_o), 96'h0);
    chk("reset_valid", 96'(out_valid_o), 96'h0);
    chk("reset_conv", out_conversion_o, 96'h0);
    chk("reset_ovr", 96'(overrun_o), 96'h0);
    @(negedge clock_i);
    reset_i = 1'b0;

    for (int a = 0; a <= ST; a++) begin
      rdx(a);
      chk("reset_sweep", 96'(out_o), 96'h0);
    end

    for (int i = 0; i < 16; i++) wr(i, 8'(8'hA0 + i));
    for (int i = 0; i < 16; i++) begin
      rdx(i);
      chk("ctrl_rd", 96'(out_o), 96'(8'hA0 + i));
    end
    wr(16, 8'h55);
    chk("ro_write_err", 96'(write_err_o), 96'h1);
    rdx(16);
    chk("ro_unchanged", 96'(out_o), 96'h0);

    cvx(1, 24'h123456);
    rdx(19);
    chk("snap_msb", 96'(out_o), 96'h12);
    cvx(1, 24'hABCDEF);
    chk("live_ch1", 96'(out_conversion_o[47:24]), 96'hABCDEF);
    rdx(20);
    chk("snap_b1", 96'(out_o), 96'h34);
    rdx(21);
    chk("snap_b2", 96'(out_o), 96'h56);
    rdx(19);
    chk("snap_msb2", 96'(out_o), 96'hAB);
    chk("no_overrun", 96'(overrun_o), 96'h0);

    cvx(2, 24'h111111);
    cvx(2, 24'h222222);
    chk("ovr_ch2", 96'(overrun_o), 96'h4);
    rdx(ST);
    chk("status_rd", 96'(out_o), 96'h04);
    rdx(ST);
    chk("status_clr", 96'(out_o), 96'h00);
    cvx(3, 24'h333333);
    step(0, 0, 0, 8'h0, 1, ST, 1, 3, 24'h444444);
    chk("status_race_rd", 96'(out_o), 96'h00);
    chk("status_race_bit", 96'(overrun_o), 96'h8);
    rdx(ST);
    chk("status_race_val", 96'(out_o), 96'h08);

    step(0, 0, 0, 8'h0, 1, 16, 1, 0, 24'h010203);
    chk("conv_rd_old", 96'(out_o), 96'h00);
    cvx(0, 24'h040506);
    chk("unread_kept", 96'(overrun_o), 96'h1);
    rdx(ST);
    step(1, 1, 5, 8'h99, 0, 0, 0, 0, 24'h0);
    rdx(5);
    chk("clear_wins", 96'(out_o), 96'h00);

    wr(3, 8'h77);
    cvx(2, 24'h000001);
    cvx(2, 24'h000002);
    rdx(3);
    chk("pre_reset_rd", 96'(out_o), 96'h77);
    read_i = 0; load_i = 0; conv_valid_i = 0; clear_i = 0;
    #2 reset_i = 1'b1;
    #1;
    chk("async_out", 96'(out_o), 96'h0);
    chk("async_valid", 96'(out_valid_o), 96'h0);
    chk("async_ovr", 96'(overrun_o), 96'h0);
    chk("async_conv", out_conversion_o, 96'h0);
    @(negedge clock_i);
    reset_i = 1'b0;
    model_reset();
    wr(2, 8'h3C);
    rdx(2);
    chk("resume", 96'(out_o), 96'h3C);

    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)), $urandom_range(0, 31),
           8'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 31),
           ($urandom_range(0, 2) == 0), $urandom_range(0, 3), 24'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
